mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester memory arbiter (CPU and debug/DMA port) in
// front of a fixed-latency memory.
//
// Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE (one cycle), so a
// request sampled in cycle 0 is answered with READY/ACK in cycle MEM_LAT+1.
// The winner's WE/ADDR/WDATA are latched at the grant edge and the requester
// inputs are ignored until the next IDLE cycle.
//
// Parameters:
//   MEM_LAT        memory latency in cycles (1..15)
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin on a tie (CPU gets the first tie)
//                  undefined -> fixed priority, CPU always wins a tie
// Ports:
//   CLK, RESET_N                         clock, async active-low reset
//   CPU_CS/WE/ADDR/WDATA -> CPU_READY/RDATA     CPU request / response
//   DBG_REQ/WE/ADDR/WDATA -> DBG_ACK/RDATA      debug request / response
//   MEM_EN/WE/ADDR/WDATA, MEM_RDATA      memory side
//   BUSY (access in flight), OWNER (0 = CPU, 1 = DBG, current or last)
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CPU_CS,
  input  logic        CPU_WE,
  input  logic [15:0] CPU_ADDR,
  input  logic [15:0] CPU_WDATA,
  output logic        CPU_READY,
  output logic [15:0] CPU_RDATA,
  input  logic        DBG_REQ,
  input  logic        DBG_WE,
  input  logic [15:0] DBG_ADDR,
  input  logic [15:0] DBG_WDATA,
  output logic        DBG_ACK,
  output logic [15:0] DBG_RDATA,
  output logic        MEM_EN,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  output logic        BUSY,
  output logic        OWNER
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic        owner_q, we_q;
  logic [15:0] addr_q, wdata_q, cpu_rd_q, dbg_rd_q;
  logic [3:0]  cnt_q;
  logic        req_any, grant_dbg, start;

  assign req_any = CPU_CS | DBG_REQ;
  assign start   = (state == IDLE) & req_any;

`ifdef MEM_ARB_RR_EN
  // rr_dbg_q = 1 means the next tie goes to DBG (i.e. CPU was served last).
  logic rr_dbg_q;
  assign grant_dbg = DBG_REQ & (~CPU_CS | rr_dbg_q);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)   rr_dbg_q <= 1'b0;
    else if (start) rr_dbg_q <= ~grant_dbg;
  end
`else
  assign grant_dbg = DBG_REQ & ~CPU_CS;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      cpu_rd_q <= '0;
      dbg_rd_q <= '0;
    end else begin
      if (start) begin
        owner_q <= grant_dbg;
        we_q    <= grant_dbg ? DBG_WE    : CPU_WE;
        addr_q  <= grant_dbg ? DBG_ADDR  : CPU_ADDR;
        wdata_q <= grant_dbg ? DBG_WDATA : CPU_WDATA;
        cnt_q   <= CNT_INIT;
      end else if (state == ACCESS) begin
        if (cnt_q == 4'd0) begin
          // last ACCESS cycle: memory data is valid, steer it to the owner
          if (!we_q) begin
            if (owner_q) dbg_rd_q <= MEM_RDATA;
            else         cpu_rd_q <= MEM_RDATA;
          end
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

  assign MEM_EN    = (state == ACCESS);
  assign MEM_WE    = MEM_EN & we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign CPU_READY = (state == DONE) & ~owner_q;
  assign DBG_ACK   = (state == DONE) &  owner_q;
  assign CPU_RDATA = cpu_rd_q;
  assign DBG_RDATA = dbg_rd_q;
  assign BUSY      = (state != IDLE);
  assign OWNER     = owner_q;
endmodule
